// File: rtl/joy_serial_multi.sv
// Serial pad-chain reader: parallel-loads the pads, shifts PLAYERS*BITS bits LSB-first on a divided tick, then commits them all at once.
// joystick/frame_done update one clk after the final SHIFT_LO tick; enable only gates new frames, never a frame already running.
module joy_serial_multi #(
  parameter int PLAYERS = 2,
  parameter int BITS    = 12,
  parameter int DIV     = 25,
  parameter int GAP     = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    joy_data,
  output logic                    joy_clk,
  output logic                    joy_load,
  output logic [PLAYERS*16-1:0]   joystick,
  output logic                    frame_done
);

  localparam int NBITS = PLAYERS * BITS;
  localparam int DW    = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SHIFT_LO, S_SHIFT_HI, S_COMMIT, S_GAP
  } state_t;

  state_t               state, state_n;
  logic [DW-1:0]        div_cnt;
  logic                 tick;
  logic [6:0]           bit_cnt, bit_n;
  logic [11:0]          gap_cnt, gap_n;
  logic [NBITS-1:0]     shreg, sh_n;
  logic [PLAYERS*16-1:0] joy_n;
  logic                 clk_n, load_n, done_n;

  assign tick = (div_cnt == DW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!reset_n)  div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      joy_clk    <= 1'b1;
      joy_load   <= 1'b1;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      shreg      <= '0;
      joystick   <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      joy_clk    <= clk_n;
      joy_load   <= load_n;
      bit_cnt    <= bit_n;
      gap_cnt    <= gap_n;
      shreg      <= sh_n;
      joystick   <= joy_n;
      frame_done <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    clk_n   = joy_clk;
    load_n  = joy_load;
    bit_n   = bit_cnt;
    gap_n   = gap_cnt;
    sh_n    = shreg;
    joy_n   = joystick;
    done_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if (tick && enable) begin
          load_n  = 1'b0;
          state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        if (tick) begin
          load_n  = 1'b1;
          bit_n   = '0;
          state_n = S_SHIFT_HI;
        end
      end
      S_SHIFT_HI: begin
        // new bit enters at the top so the first sample ends up at bit 0
        if (tick) begin
          sh_n    = {~joy_data, shreg[NBITS-1:1]};
          clk_n   = 1'b0;
          state_n = S_SHIFT_LO;
        end
      end
      S_SHIFT_LO: begin
        if (tick) begin
          clk_n   = 1'b1;
          bit_n   = bit_cnt + 7'd1;
          state_n = (bit_n == 7'(NBITS)) ? S_COMMIT : S_SHIFT_HI;
        end
      end
      S_COMMIT: begin
        joy_n = '0;
        for (int p = 0; p < PLAYERS; p++)
          joy_n[16*p +: BITS] = shreg[p*BITS +: BITS];
        done_n  = 1'b1;
        gap_n   = '0;
        state_n = S_GAP;
      end
      S_GAP: begin
        if (tick) begin
          if (gap_cnt == 12'(GAP)) state_n = S_IDLE;
          else                     gap_n   = gap_cnt + 12'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: doc/joy_serial_multi.md
JOY_SERIAL_MULTI -- requirements
Module: joy_serial_multi

Interface
REQ-001 SHALL have parameter PLAYERS, default 2, number of daisy-chained pads (1..4).
REQ-002 SHALL have parameter BITS, default 12, button bits per pad (4..16).
REQ-003 SHALL have parameter DIV, default 25, clk cycles per serial tick (1..1023).
REQ-004 SHALL have parameter GAP, default 64, idle ticks between frames (0..4095).
REQ-005 SHALL have port clk  input  1  single system clock (40-50 MHz); all logic on its rising edge.
REQ-006 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-007 SHALL have port enable  input  1  allow new frames to start.
REQ-008 SHALL have port joy_data  input  1  serial data from the shift-register chain; 0 = button pressed.
REQ-009 SHALL have port joy_clk  output  1  serial shift clock to the pads; idles high.
REQ-010 SHALL have port joy_load  output  1  parallel-load strobe to the pads, active low.
REQ-011 SHALL have port joystick  output  PLAYERS*16  pad p in bits [16p+15:16p]; bit b = button b, 1 = pressed; bits BITS..15 of each field are 0.
REQ-012 SHALL have port frame_done  output  1  one-clk pulse when joystick updates.

Function
REQ-013 SHALL generate tick as a one-clk pulse every DIV clk cycles from a free-running divider that restarts at 0 on reset and wraps after DIV-1; DIV=1 gives tick on every cycle.
REQ-014 SHALL change state and change joy_clk/joy_load only on tick cycles.
REQ-015 SHALL implement states IDLE, LOAD, SHIFT_LO, SHIFT_HI, COMMIT, GAP.
REQ-016 In IDLE on tick with enable=1, SHALL go to LOAD and drive joy_load=0; with enable=0 it SHALL remain in IDLE.
REQ-017 LOAD SHALL last exactly one tick; the next tick SHALL set joy_load=1, clear the bit counter and enter SHIFT_HI.
REQ-018 In SHIFT_HI on tick, SHALL sample joy_data, shift ~joy_data into the LSB-first shift register, drive joy_clk=0 and enter SHIFT_LO.
REQ-019 In SHIFT_LO on tick, SHALL drive joy_clk=1 and increment the bit counter.
REQ-020 If the counter reaches PLAYERS*BITS, SHALL enter COMMIT; otherwise it SHALL return to SHIFT_HI.
REQ-021 The first bit sampled SHALL be pad 0 bit 0; bit k in the stream SHALL map to pad k/BITS, button k mod BITS.
REQ-022 A frame SHALL contain exactly PLAYERS*BITS joy_clk low pulses, each one tick low and one tick high.
REQ-023 COMMIT SHALL update all joystick fields in the same clk cycle and assert frame_done for exactly that cycle, without waiting for tick; it SHALL then enter GAP.
REQ-024 joystick SHALL never expose a partially shifted frame.
REQ-025 GAP SHALL count GAP ticks, then enter IDLE; with GAP=0 it SHALL enter IDLE on the next tick.
REQ-026 Deasserting enable mid-frame SHALL NOT abort the frame; it SHALL take effect only in IDLE.
REQ-027 The bit counter SHALL be wide enough for 64 and SHALL never wrap within a frame.
REQ-028 The shift register SHALL hold PLAYERS*BITS bits; no bit may be lost or duplicated.
REQ-029 Latency from the final sample to the joystick update SHALL be the following SHIFT_LO tick plus 1 clk.

Reset
REQ-030 While reset_n=0 at a clk edge, SHALL set state=IDLE, joy_clk=1, joy_load=1, joystick=0, frame_done=0, divider=0, bit counter=0 and shift register=0.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame, leave joystick=0 and leave no truncated joy_clk pulse beyond the reset cycle.
REQ-032 After reset_n rises, the first LOAD SHALL occur on the first tick with enable=1, DIV clk cycles after release.

Verification
REQ-033 Scenario A: PLAYERS=2, BITS=12, DIV=4, pad model returns 0x001 for pad 0 and 0x800 for pad 1 -> joystick=0x0800_0001, one frame_done, 24 joy_clk pulses, each low for 4 clk.
REQ-034 Scenario B: joy_data stuck 1 -> joystick=0 after every frame; stuck 0 -> each field =0x0FFF with bits 12..15 =0.
REQ-035 Scenario C: reset_n=0 asserted after the 10th joy_clk pulse -> the next clk shows joystick=0, joy_clk=1, joy_load=1, and there is no frame_done.
REQ-036 Scenario D: enable dropped at bit 5 -> the frame completes with frame_done; no joy_load follows while enable=0.
REQ-037 Scenario E: DIV=1, GAP=0, PLAYERS=1, BITS=4 -> frame period = 1 LOAD + 8 SHIFT + 1 COMMIT + 1 GAP + 1 IDLE ticks, stable across 3 frames.
REQ-038 Scenario F: pad data changes between frames -> joystick holds the old value until the COMMIT cycle, then switches in one clk.
